// File: rtl/mna_pkg.sv
// Shared constants and state encoding for the master network adapter
// request-path VC allocator.
package mna_pkg;

  localparam int NUM_VC_DEF = 8;
  localparam int FLIT_W_DEF = 37;

  localparam logic [1:0] FLIT_HEAD = 2'b10;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr_i,
// wrapping modulo N, returned as one-hot grant plus index.
module rr_picker #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return s[IW-1:0];
  endfunction

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = wrap_add(ptr_i, k);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mna_vc_allocator.sv
// VC allocator and packet sequencer: grants one eligible VC per packet in
// round-robin order, holds it until the tail flit, tracks VC occupancy.
module mna_vc_allocator
  import mna_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int FLIT_W = FLIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_req,
  input  logic [NUM_VC-1:0] vc_mask,
  input  logic [NUM_VC-1:0] vc_on_off,
  input  logic [NUM_VC-1:0] vc_free_ret,
  input  logic              flit_valid,
  input  logic [1:0]        flit_type,
  output logic [NUM_VC-1:0] vc_grant,
  output logic              grant_valid,
  output logic [NUM_VC-1:0] vc_busy,
  output logic              err_proto,
  output state_e            dbg_state
);

  localparam int PW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  // The type field only exists when the flit is wide enough to carry it.
  localparam logic [1:0] TYPE_MASK = (FLIT_W >= 2) ? 2'b11 : 2'b00;

  // Handshake: flit_valid is a one-cycle qualifier sampled on every rising
  // edge while a grant is held; there is no ready, the packetizer only
  // sends once it sees vc_grant non-zero and honours vc_on_off itself.

  state_e            state_q, state_d;
  logic [NUM_VC-1:0] grant_q, grant_d;
  logic              gv_q, gv_d;
  logic [NUM_VC-1:0] busy_q, busy_d;
  logic              err_q, err_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic [NUM_VC-1:0] elig;
  logic [NUM_VC-1:0] pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_valid;
  logic [1:0]        ftype;
  logic [NUM_VC-1:0] busy_set;
  logic [NUM_VC-1:0] bad_free;
  logic [NUM_VC-1:0] held_free;
  logic              err_set;

  assign elig  = ~busy_q & vc_mask & vc_on_off;
  assign ftype = flit_type & TYPE_MASK;

  rr_picker #(.N(NUM_VC), .IW(PW)) u_picker (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gv_d      = gv_q;
    ptr_d     = ptr_q;
    busy_set  = '0;
    err_set   = 1'b0;
    bad_free  = '0;
    held_free = '0;

    case (state_q)
      ST_IDLE: begin
        if (flit_valid) err_set = 1'b1;
        if (pkt_req && pick_valid) begin
          grant_d  = pick_gnt;
          gv_d     = 1'b1;
          busy_set = pick_gnt;
          ptr_d    = (pick_idx == PW'(NUM_VC - 1)) ? '0 : pick_idx + 1'b1;
          state_d  = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (flit_valid) begin
          if (ftype == FLIT_HEAD) state_d = ST_BODY;
          else                    err_set = 1'b1;
        end
      end
      ST_BODY: begin
        if (flit_valid) begin
          if (ftype == FLIT_TAIL) begin
            grant_d = '0;
            gv_d    = 1'b0;
            state_d = ST_IDLE;
          end else if (ftype != FLIT_BODY) begin
            err_set = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        gv_d    = 1'b0;
      end
    endcase

    // A return for the VC still held means the router released it before
    // the tail left; keep it busy so it cannot be reallocated mid-packet.
    bad_free  = vc_free_ret & ~busy_q;
    held_free = (state_q != ST_IDLE) ? (vc_free_ret & busy_q & grant_q) : '0;
    if ((|bad_free) || (|held_free)) err_set = 1'b1;

    busy_d = (busy_q & ~(vc_free_ret & ~held_free)) | busy_set;
    err_d  = err_q | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
      busy_q  <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= gv_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
    end
  end

  assign vc_grant    = grant_q;
  assign grant_valid = gv_q;
  assign vc_busy     = busy_q;
  assign err_proto   = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mna_vc_allocator.sv
// Directed bench for mna_vc_allocator: expectations queued at stimulus time,
// popped and asserted once the DUT outputs settle.
module tb_mna_vc_allocator;
  import mna_pkg::*;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pkt_req = 1'b0;
  logic [7:0] vc_mask = 8'hFF;
  logic [7:0] vc_on_off = 8'hFF;
  logic [7:0] vc_free_ret = 8'h00;
  logic       flit_valid = 1'b0;
  logic [1:0] flit_type = 2'b00;
  logic [7:0] vc_grant;
  logic       grant_valid;
  logic [7:0] vc_busy;
  logic       err_proto;
  state_e     dbg_state;

  logic [W-1:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  mna_vc_allocator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pkt_req     (pkt_req),
    .vc_mask     (vc_mask),
    .vc_on_off   (vc_on_off),
    .vc_free_ret (vc_free_ret),
    .flit_valid  (flit_valid),
    .flit_type   (flit_type),
    .vc_grant    (vc_grant),
    .grant_valid (grant_valid),
    .vc_busy     (vc_busy),
    .err_proto   (err_proto),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic flit(input logic [1:0] t);
    flit_valid = 1'b1;
    flit_type  = t;
    cyc();
    flit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pkt_req = 1'b0;
    vc_free_ret = 8'h00;
    flit_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] g);
    push(W'(g));
    push(W'(1));
    push(W'(ST_HEAD));
    pkt_req = 1'b1;
    cyc();
    chk("grant", W'(vc_grant));
    chk("grant_valid", W'(grant_valid));
    chk("state_head", W'(dbg_state));
    pkt_req = 1'b0;
    flit(FLIT_HEAD);
    flit(FLIT_BODY);
    push(W'(0));
    push(W'(ST_IDLE));
    flit(FLIT_TAIL);
    chk("grant_after_tail", W'(vc_grant));
    chk("state_after_tail", W'(dbg_state));
  endtask

  initial begin
    #2;
    push(W'(0)); push(W'(0)); push(W'(0)); push(W'(0));
    chk("rst_grant", W'(vc_grant));
    chk("rst_gv", W'(grant_valid));
    chk("rst_busy", W'(vc_busy));
    chk("rst_err", W'(err_proto));
    cyc();
    rst_n = 1'b1;

    // First grant, round-robin 0,1,2
    push(W'(8'h01));
    pkt_req = 1'b1;
    cyc();
    chk("first_busy", W'(vc_busy));
    pkt_req = 1'b0;
    flit(FLIT_HEAD); flit(FLIT_BODY);
    push(W'(8'h01)); push(W'(0));
    flit(FLIT_TAIL);
    chk("busy_after_tail", W'(vc_busy));
    chk("gv_after_tail", W'(grant_valid));
    send_pkt(8'h02);
    send_pkt(8'h04);
    push(W'(8'h07));
    cyc();
    chk("busy_three", W'(vc_busy));

    // Return all, then walk pointer to 7 and wrap
    push(W'(0)); push(W'(0));
    vc_free_ret = 8'h07;
    cyc();
    vc_free_ret = 8'h00;
    chk("busy_returned", W'(vc_busy));
    chk("err_clean_return", W'(err_proto));
    send_pkt(8'h08);
    send_pkt(8'h10);
    send_pkt(8'h20);
    send_pkt(8'h40);
    send_pkt(8'h80);
    send_pkt(8'h01);
    push(W'(8'hF9));
    cyc();
    chk("busy_wrap", W'(vc_busy));
    push(W'(0));
    vc_free_ret = 8'hF9;
    cyc();
    vc_free_ret = 8'h00;
    chk("busy_cleared", W'(vc_busy));

    // No eligible VC for 10 cycles
    vc_mask = 8'h10;
    vc_on_off = 8'hEF;
    pkt_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(W'(0));
      cyc();
      chk("no_elig_grant", W'(vc_grant));
    end
    push(W'(0));
    chk("no_elig_err", W'(err_proto));
    vc_on_off = 8'hFF;
    push(W'(8'h10));
    cyc();
    chk("on_raised_grant", W'(vc_grant));
    pkt_req = 1'b0;
    flit(FLIT_HEAD); flit(FLIT_BODY); flit(FLIT_TAIL);

    // Return and allocation in the same cycle
    vc_mask = 8'h01;
    send_pkt(8'h01);
    push(W'(0)); push(W'(0)); push(W'(8'h10));
    vc_free_ret = 8'h01;
    pkt_req = 1'b1;
    cyc();
    vc_free_ret = 8'h00;
    chk("same_cycle_grant", W'(vc_grant));
    chk("same_cycle_gv", W'(grant_valid));
    chk("same_cycle_busy", W'(vc_busy));
    push(W'(8'h01));
    cyc();
    chk("next_cycle_grant", W'(vc_grant));
    pkt_req = 1'b0;
    flit(FLIT_HEAD); flit(FLIT_BODY); flit(FLIT_TAIL);
    push(W'(0));
    chk("err_still_clean", W'(err_proto));
    vc_mask = 8'hFF;

    // BODY flit while in HEAD
    do_reset();
    pkt_req = 1'b1;
    cyc();
    pkt_req = 1'b0;
    push(W'(1)); push(W'(ST_HEAD));
    flit(FLIT_BODY);
    chk("err_body_in_head", W'(err_proto));
    chk("state_stays_head", W'(dbg_state));
    push(W'(1));
    cyc();
    chk("err_sticky", W'(err_proto));

    // flit_valid in IDLE
    do_reset();
    push(W'(1)); push(W'(0));
    flit(FLIT_HEAD);
    chk("err_flit_idle", W'(err_proto));
    chk("idle_flit_no_grant", W'(vc_grant));

    // Return on non-busy VC
    do_reset();
    push(W'(1)); push(W'(0));
    vc_free_ret = 8'h04;
    cyc();
    vc_free_ret = 8'h00;
    chk("err_free_idle_vc", W'(err_proto));
    chk("busy_unchanged", W'(vc_busy));

    // Return on the held VC
    do_reset();
    pkt_req = 1'b1;
    cyc();
    pkt_req = 1'b0;
    push(W'(1)); push(W'(8'h01)); push(W'(8'h01));
    vc_free_ret = 8'h01;
    cyc();
    vc_free_ret = 8'h00;
    chk("err_free_held", W'(err_proto));
    chk("held_busy_kept", W'(vc_busy));
    chk("held_grant_kept", W'(vc_grant));

    // Reset mid-packet
    do_reset();
    pkt_req = 1'b1;
    cyc();
    pkt_req = 1'b0;
    flit(FLIT_HEAD);
    vc_free_ret = 8'h40;
    push(W'(1)); push(W'(ST_BODY));
    cyc();
    vc_free_ret = 8'h00;
    chk("err_before_reset", W'(err_proto));
    chk("in_body", W'(dbg_state));
    #2;
    rst_n = 1'b0;
    #1;
    push(W'(0)); push(W'(0)); push(W'(0)); push(W'(0));
    chk("async_rst_grant", W'(vc_grant));
    chk("async_rst_busy", W'(vc_busy));
    chk("async_rst_err", W'(err_proto));
    chk("async_rst_gv", W'(grant_valid));
    cyc();
    rst_n = 1'b1;
    push(W'(8'h01));
    pkt_req = 1'b1;
    cyc();
    pkt_req = 1'b0;
    chk("post_reset_grant", W'(vc_grant));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
